// File: rtl/strela_csr_sequencer.sv
// strela_csr_sequencer: turns a WRITE/READ/POLL/END command stream into reg_req/reg_rsp transactions.
module strela_csr_sequencer #(
  parameter type reg_req_t = struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  },
  parameter type reg_rsp_t = struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  },
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]           cmd_data_i,
  output reg_req_t              reg_req_o,
  input  reg_rsp_t              reg_rsp_i,
  output logic [31:0]           rdata_o,
  output logic                  rdata_valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [1:0]            err_code_o
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, REQ = 3'd2, POLL_GAP = 3'd3, DONE = 3'd4;
  localparam logic [1:0] OP_WRITE = 2'd0, OP_READ = 2'd1, OP_POLL = 2'd2, OP_END = 2'd3;
  localparam int CW = $clog2(POLL_TIMEOUT + 1);
  logic [2:0]    state;
  logic [1:0]    op;
  logic [31:0]   mask;
  logic [CW-1:0] poll_cnt;
  logic          hit, timeout, is_wr;
  assign cmd_ready_o = state == FETCH;
  assign busy_o      = state != IDLE;
  assign done_o      = state == DONE;
  assign hit         = |(reg_rsp_i.rdata & mask);
  assign timeout     = poll_cnt + 1'b1 == CW'(POLL_TIMEOUT);
  assign is_wr       = cmd_op_i == OP_WRITE;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      op            <= OP_WRITE;
      mask          <= '0;
      poll_cnt      <= '0;
      reg_req_o     <= '0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      error_o       <= 1'b0;
      err_code_o    <= 2'd0;
    end else begin
      rdata_valid_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          error_o    <= 1'b0;
          err_code_o <= 2'd0;
          state      <= FETCH;
        end
        FETCH: if (cmd_valid_i) begin
          if (cmd_op_i == OP_END) state <= DONE;
          else begin
            op              <= cmd_op_i;
            mask            <= cmd_data_i;
            poll_cnt        <= '0;
            state           <= REQ;
            reg_req_o.valid <= 1'b1;
            reg_req_o.addr  <= 32'(cmd_addr_i);
            reg_req_o.write <= is_wr;
            reg_req_o.wdata <= is_wr ? cmd_data_i : '0;
            reg_req_o.wstrb <= is_wr ? '1 : '0;
          end
        end
        REQ: if (reg_rsp_i.ready) begin
          reg_req_o.valid <= 1'b0;
          if (op != OP_WRITE) rdata_o <= reg_rsp_i.rdata;
          if (op == OP_POLL) poll_cnt <= poll_cnt + 1'b1;
          // a bus error aborts the whole sequence, even on a READ
          if (reg_rsp_i.error) begin
            error_o    <= 1'b1;
            err_code_o <= 2'd1;
            state      <= DONE;
          end else if (op == OP_READ) begin
            rdata_valid_o <= 1'b1;
            state         <= FETCH;
          end else if (op == OP_WRITE || hit) state <= FETCH;
          else if (timeout) begin
            error_o    <= 1'b1;
            err_code_o <= 2'd2;
            state      <= DONE;
          end else state <= POLL_GAP;
        end
        POLL_GAP: begin
          reg_req_o.valid <= 1'b1;
          state           <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
